regfile_access_arbiter: RTL and testbench

- Shares the 32x32 register file (1 write port, 2 read ports, reads registered on the clock edge) between NUM_REQ independent requesters, e.g. pipeline writeback/decode and a debug/loader port.
- Accepts one request per grant over a valid/ready handshake and drives the register file ports for exactly one issue cycle.
- Captures the read data one cycle later and returns it with the requester ID over a valid/ready response channel.
- Enforces register 0 semantics: hardwired zero, writes ignored.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_access_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_access_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants, arbiter state encoding and request record.
package regfile_pkg;

    localparam int             RF_ADDR_W   = 5;
    localparam int             RF_DATA_W   = 32;
    localparam logic [4:0]     RF_ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                 write;
        logic [RF_ADDR_W-1:0] rd1;
        logic [RF_ADDR_W-1:0] rd2;
        logic [RF_ADDR_W-1:0] wr_reg;
        logic [RF_DATA_W-1:0] wr_data;
    } rf_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares one 2R/1W register file among NUM_REQ requesters: grant, issue for one
// cycle, capture registered read data, return it over a valid/ready response.
module regfile_access_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*RF_ADDR_W-1:0]   req_read_reg1,
    input  logic [NUM_REQ*RF_ADDR_W-1:0]   req_read_reg2,
    input  logic [NUM_REQ*RF_ADDR_W-1:0]   req_write_reg,
    input  logic [NUM_REQ*RF_DATA_W-1:0]   req_write_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [RF_DATA_W-1:0]           rsp_data1,
    output logic [RF_DATA_W-1:0]           rsp_data2,
    output logic                           rf_write,
    output logic [RF_ADDR_W-1:0]           rf_read_reg1,
    output logic [RF_ADDR_W-1:0]           rf_read_reg2,
    output logic [RF_ADDR_W-1:0]           rf_write_reg,
    output logic [RF_DATA_W-1:0]           rf_write_data,
    input  logic [RF_DATA_W-1:0]           rf_read_data1,
    input  logic [RF_DATA_W-1:0]           rf_read_data2
);

    state_t                  state, state_nxt;
    logic [ID_W-1:0]         rr_ptr, ptr_nxt, pending_id, gnt_idx;
    logic [NUM_REQ-1:0]      gnt;
    logic                    issue, z1, z2;
    rf_req_t [NUM_REQ-1:0]   req_a;
    rf_req_t                 req_sel;
    logic [RF_ADDR_W-1:0]    held_rd1, held_rd2, held_wr_reg;
    logic [RF_DATA_W-1:0]    held_wr_data;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign req_a[g] = '{
            write:   req_write[g],
            rd1:     req_read_reg1[g*RF_ADDR_W +: RF_ADDR_W],
            rd2:     req_read_reg2[g*RF_ADDR_W +: RF_ADDR_W],
            wr_reg:  req_write_reg[g*RF_ADDR_W +: RF_ADDR_W],
            wr_data: req_write_data[g*RF_DATA_W +: RF_DATA_W]
        };
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // rst_n gates the grant so nothing is accepted while reset is held.
    assign issue   = rst_n && (|req_valid) &&
                     ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));
    assign req_sel = req_a[gnt_idx];
    assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    assign req_ready     = issue ? gnt : '0;
    assign rf_write      = issue && req_sel.write && (req_sel.wr_reg != RF_ZERO_REG);
    assign rf_read_reg1  = issue ? req_sel.rd1     : held_rd1;
    assign rf_read_reg2  = issue ? req_sel.rd2     : held_rd2;
    assign rf_write_reg  = issue ? req_sel.wr_reg  : held_wr_reg;
    assign rf_write_data = issue ? req_sel.wr_data : held_wr_data;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue) state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = issue ? ST_WAIT : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            pending_id   <= '0;
            z1           <= 1'b0;
            z2           <= 1'b0;
            held_rd1     <= '0;
            held_rd2     <= '0;
            held_wr_reg  <= '0;
            held_wr_data <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data1    <= '0;
            rsp_data2    <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                rr_ptr       <= ptr_nxt;
                pending_id   <= gnt_idx;
                z1           <= (req_sel.rd1 == RF_ZERO_REG);
                z2           <= (req_sel.rd2 == RF_ZERO_REG);
                held_rd1     <= req_sel.rd1;
                held_rd2     <= req_sel.rd2;
                held_wr_reg  <= req_sel.wr_reg;
                held_wr_data <= req_sel.wr_data;
            end
            // File output settles during WAIT; r0 is forced to zero on capture.
            if (state == ST_WAIT) begin
                rsp_valid <= 1'b1;
                rsp_id    <= pending_id;
                rsp_data1 <= z1 ? '0 : rf_read_data1;
                rsp_data2 <= z2 ? '0 : rf_read_data2;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench: arbiter plus a write-first register file model with a load path.
module tb_regfile_access_arbiter;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_write;
    logic [N*5-1:0]  req_read_reg1, req_read_reg2, req_write_reg;
    logic [N*32-1:0] req_write_data;
    logic            rsp_valid, rsp_ready;
    logic [0:0]      rsp_id;
    logic [31:0]     rsp_data1, rsp_data2;
    logic            rf_write;
    logic [4:0]      rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [31:0]     rf_write_data, rf_read_data1, rf_read_data2;

    logic [31:0] mem [32];
    logic        load_en;
    logic [4:0]  load_a;
    logic [31:0] load_d;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_access_arbiter #(.NUM_REQ(N), .ID_W(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_read_reg1(req_read_reg1), .req_read_reg2(req_read_reg2),
        .req_write_reg(req_write_reg), .req_write_data(req_write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rf_write(rf_write), .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
    );

    // Register file: write lands before the read is sampled on the same edge.
    always @(posedge clk) begin
        if (load_en) begin
            mem[load_a] <= load_d;
        end else begin
            if (rf_write) mem[rf_write_reg] <= rf_write_data;
            rf_read_data1 <= (rf_write && rf_write_reg == rf_read_reg1) ? rf_write_data : mem[rf_read_reg1];
            rf_read_data2 <= (rf_write && rf_write_reg == rf_read_reg2) ? rf_write_data : mem[rf_read_reg2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] wr, input logic [31:0] wd);
        req_valid[i]               = v;
        req_write[i]               = w;
        req_read_reg1[i*5 +: 5]    = r1;
        req_read_reg2[i*5 +: 5]    = r2;
        req_write_reg[i*5 +: 5]    = wr;
        req_write_data[i*32 +: 32] = wd;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        load_en = 1'b1; load_a = a; load_d = d;
        step();
        load_en = 1'b0;
    endtask

    logic [1:0] exp_g;

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1; load_en = 1'b0; load_a = '0; load_d = '0;
        req_valid = '0; req_write = '0; req_read_reg1 = '0; req_read_reg2 = '0;
        req_write_reg = '0; req_write_data = '0;
        set_req(0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd0, 32'h0);
        #3;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id",    32'(rsp_id),    32'h0);
        check("rst_rsp_data1", rsp_data1,      32'h0);
        check("rst_rf_write",  32'(rf_write),  32'h0);
        check("rst_rf_addr1",  32'(rf_read_reg1), 32'h0);
        req_valid = '0;
        for (int r = 0; r < 32; r++) load(5'(r), 32'h0);
        load(5'd0, 32'hBAD0BAD0);
        load(5'd3, 32'h11);
        load(5'd4, 32'h22);
        rst_n = 1'b1;
        step();

        // Single read
        set_req(0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
        #1;
        check("rd_ready",  32'(req_ready), 32'h1);
        check("rd_addr1",  32'(rf_read_reg1), 32'd3);
        check("rd_addr2",  32'(rf_read_reg2), 32'd4);
        step(); req_valid = '0; #1;
        check("rd_wait_ready", 32'(req_ready), 32'h0);
        check("rd_wait_valid", 32'(rsp_valid), 32'h0);
        check("rd_wait_addr1", 32'(rf_read_reg1), 32'd3);
        step();
        check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd_rsp_id",    32'(rsp_id),    32'h0);
        check("rd_rsp_data1", rsp_data1, 32'h11);
        check("rd_rsp_data2", rsp_data2, 32'h22);
        step();
        check("rd_idle_valid", 32'(rsp_valid), 32'h0);

        // Register 0 write and reads
        set_req(1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hDEAD);
        #1;
        check("r0_ready", 32'(req_ready), 32'h2);
        check("r0_rf_write", 32'(rf_write), 32'h0);
        step(); req_valid = '0;
        step();
        check("r0_rsp_id",    32'(rsp_id), 32'h1);
        check("r0_rsp_data1", rsp_data1, 32'h0);
        check("r0_rsp_data2", rsp_data2, 32'h0);
        step();
        set_req(0, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0);
        step(); req_valid = '0;
        step();
        check("r0_again_data1", rsp_data1, 32'h0);
        check("r0_again_data2", rsp_data2, 32'h11);
        step();

        // Write-then-read same address
        set_req(0, 1'b1, 1'b1, 5'd7, 5'd4, 5'd7, 32'hCAFEF00D);
        #1;
        check("wr_ready",    32'(req_ready), 32'h1);
        check("wr_rf_write", 32'(rf_write), 32'h1);
        check("wr_rf_reg",   32'(rf_write_reg), 32'd7);
        check("wr_rf_data",  rf_write_data, 32'hCAFEF00D);
        step(); req_valid = '0; #1;
        check("wr_wait_nowrite", 32'(rf_write), 32'h0);
        step();
        check("wr_rsp_data1", rsp_data1, 32'hCAFEF00D);
        check("wr_rsp_data2", rsp_data2, 32'h22);
        step();
        set_req(1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
        step(); req_valid = '0;
        step();
        check("wr_rd1_id",    32'(rsp_id), 32'h1);
        check("wr_rd1_data1", rsp_data1, 32'hCAFEF00D);
        check("wr_rd1_data2", rsp_data2, 32'h0);
        step();

        // Round-robin with both requesters valid; req1 also writes r9
        set_req(0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
        set_req(1, 1'b1, 1'b1, 5'd4, 5'd3, 5'd9, 32'h99);
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_g = (k % 2 != 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(exp_g));
            check($sformatf("rr_write_%0d", k), 32'(rf_write), 32'(exp_g == 2'b10));
            if (k % 2 == 0 && k > 0) begin
                check($sformatf("rr_rsp_id_%0d", k), 32'(rsp_id), 32'(((k / 2) % 2 == 0) ? 1 : 0));
                check($sformatf("rr_rsp_d1_%0d", k), rsp_data1, ((k / 2) % 2 == 0) ? 32'h22 : 32'h11);
            end
            step();
        end

        // Backpressure: last grant went to req1
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready",   32'(req_ready), 32'h0);
            check("bp_rf_write", 32'(rf_write), 32'h0);
            check("bp_valid",   32'(rsp_valid), 32'h1);
            check("bp_id",      32'(rsp_id), 32'h1);
            check("bp_data1",   rsp_data1, 32'h22);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_next_grant", 32'(req_ready), 32'h1);
        step(); req_valid = '0; #1;
        check("bp_drop_valid", 32'(rsp_valid), 32'h0);
        step();
        check("bp_rsp_id",    32'(rsp_id), 32'h0);
        check("bp_rsp_data2", rsp_data2, 32'h22);
        step();

        // r9 was written by req1 during round-robin
        set_req(0, 1'b1, 1'b0, 5'd9, 5'd3, 5'd0, 32'h0);
        step(); req_valid = '0;
        step();
        check("r9_data1", rsp_data1, 32'h99);
        step();

        // Async reset while in WAIT
        set_req(1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
        #1;
        check("ar_pre_grant", 32'(req_ready), 32'h2);
        step();
        set_req(0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rsp_valid", 32'(rsp_valid), 32'h0);
        check("ar_req_ready", 32'(req_ready), 32'h0);
        step();
        check("ar_held_valid", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        check("ar_first_grant", 32'(req_ready), 32'h1);
        step(); req_valid = '0;
        step();
        check("ar_rsp_id",    32'(rsp_id), 32'h0);
        check("ar_rsp_data1", rsp_data1, 32'h11);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
